// File: rtl/pos_cache_dbuf.sv
// pos_cache_dbuf: double-buffered multi-channel particle position cache; define POS_CACHE_OUT_REG_EN for a registered read output
module pos_cache_dbuf #(
  parameter int DATA_WIDTH    = 32,
  parameter int PARTICLE_NUM  = 220,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_X        = 1,
  parameter int CELL_Y        = 1,
  parameter int CELL_Z        = 1,
  parameter int NUM_CH        = 2,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              motion_update_enable,
  input  logic [ADDR_WIDTH-1:0]             in_read_address,
  input  logic                              in_rden,
  input  logic [NUM_CH*3*DATA_WIDTH-1:0]    in_data,
  input  logic [NUM_CH*3*CELL_ID_WIDTH-1:0] in_data_dst_cell,
  input  logic [NUM_CH-1:0]                 in_data_valid,
  output logic                              in_ready,
  output logic [3*DATA_WIDTH-1:0]           out_particle_info,
  output logic [ADDR_WIDTH-1:0]             out_particle_num,
  output logic                              out_busy,
  output logic                              out_overflow
);
  localparam int REC_W = 3*DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PRELOAD_NUM = 3;
  localparam logic [ADDR_WIDTH:0] PN = (ADDR_WIDTH+1)'(PARTICLE_NUM);
  localparam logic [PTR_W:0] RDY_MAX = (PTR_W+1)'(FIFO_DEPTH-NUM_CH);
  localparam logic [3*CELL_ID_WIDTH-1:0] SELF = {CELL_ID_WIDTH'(CELL_X), CELL_ID_WIDTH'(CELL_Y), CELL_ID_WIDTH'(CELL_Z)};
  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, WRITE_NUM, SWAP} state_t;
  state_t state_q, state_d;
  logic active_q, active_d, ovf_q, ovf_d;
  logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d, cnt_m1;
  logic [ADDR_WIDTH-1:0] num_q, num_d, wa;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] cnt_q, cnt_d, n_push;
  logic [REC_W-1:0] rd_q, rd_d, wd;
  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [REC_W-1:0] bank0 [2**ADDR_WIDTH];
  logic [REC_W-1:0] bank1 [2**ADDR_WIDTH];
  logic [NUM_CH-1:0] match;
  logic [PTR_W-1:0] slot [NUM_CH];
  logic cap, push, drop, pop, wr_data, we, start;
  // Bank 0 power-up image: count at address 0, then a fixed coordinate pattern
  function automatic logic [REC_W-1:0] preload(int a);
    return a == 0 ? REC_W'(PRELOAD_NUM) :
           a <= PRELOAD_NUM ? {DATA_WIDTH'(a+200), DATA_WIDTH'(a+100), DATA_WIDTH'(a)} : '0;
  endfunction
  assign in_ready = cnt_q <= RDY_MAX;
  assign out_busy = state_q != IDLE;
  assign out_overflow = ovf_q;
  assign out_particle_num = num_q;
  always_comb begin
    start = state_q == IDLE && motion_update_enable;
    cap = start || state_q == COLLECT;
    n_push = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = in_data_valid[c] && in_data_dst_cell[c*3*CELL_ID_WIDTH +: 3*CELL_ID_WIDTH] == SELF;
      slot[c] = wr_ptr_q + n_push[PTR_W-1:0];
      n_push = n_push + (PTR_W+1)'(match[c]);
    end
    push = cap && |match && in_ready;
    drop = cap && |match && !in_ready;
    pop = (state_q == COLLECT || state_q == DRAIN) && cnt_q != '0;
    wr_data = pop && wr_cnt_q != PN;
    we = wr_data || state_q == WRITE_NUM;
    cnt_m1 = wr_cnt_q - (ADDR_WIDTH+1)'(1);
    wa = state_q == WRITE_NUM ? '0 : wr_cnt_q[ADDR_WIDTH-1:0];
    wd = state_q == WRITE_NUM ? REC_W'(cnt_m1[ADDR_WIDTH-1:0]) : fifo_mem[rd_ptr_q];
    wr_ptr_d = push ? wr_ptr_q + n_push[PTR_W-1:0] : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d = cnt_q + (push ? n_push : '0) - (PTR_W+1)'(pop);
    wr_cnt_d = start ? (ADDR_WIDTH+1)'(1) : wr_cnt_q + (ADDR_WIDTH+1)'(wr_data);
    ovf_d = drop || (pop && !wr_data) || (ovf_q && !start);
    num_d = state_q == SWAP ? cnt_m1[ADDR_WIDTH-1:0] : num_q;
    active_d = active_q ^ (state_q == SWAP);
    rd_d = !in_rden ? rd_q : active_q ? bank1[in_read_address] : bank0[in_read_address];
    state_d = state_q;
    case (state_q)
      IDLE:      if (motion_update_enable) state_d = COLLECT;
      COLLECT:   if (!motion_update_enable) state_d = DRAIN;
      DRAIN:     if (cnt_q == '0) state_d = WRITE_NUM;
      WRITE_NUM: state_d = SWAP;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      active_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_cnt_q <= (ADDR_WIDTH+1)'(1);
      num_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      for (int a = 0; a < 2**ADDR_WIDTH; a++) begin
        bank0[a] <= preload(a);
        bank1[a] <= '0;
      end
    end else begin
      state_q <= state_d;
      active_q <= active_d;
      ovf_q <= ovf_d;
      wr_cnt_q <= wr_cnt_d;
      num_q <= num_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      if (we && active_q) bank0[wa] <= wd;
      if (we && !active_q) bank1[wa] <= wd;
    end
  end
  always_ff @(posedge clk) begin
    if (push)
      for (int c = 0; c < NUM_CH; c++)
        if (match[c]) fifo_mem[slot[c]] <= in_data[c*REC_W +: REC_W];
  end
`ifdef POS_CACHE_OUT_REG_EN
  logic [REC_W-1:0] out_q;
  always_ff @(posedge clk) out_q <= rst ? '0 : rd_q;
  assign out_particle_info = out_q;
`else
  assign out_particle_info = rd_q;
`endif
endmodule

// File: doc/pos_cache_dbuf.md
# pos_cache_dbuf

Double-buffered, parametrised particle position cache for one cell of the range-limited MD pipeline. It serves position reads to force evaluation from the active bank. During motion update it collects particles broadcast on NUM_CH parallel channels into the shadow bank, writes the particle count to address 0, and swaps banks. It is the multi-channel successor of the per-cell position caches instantiated by the RL_LJ top level, and adds input backpressure, overflow detection and a readable particle count.

## Interface
- DATA_WIDTH, 32: width of one coordinate; a record is {posz, posy, posx}, 3*DATA_WIDTH bits.
- PARTICLE_NUM, 220: bank depth. Address 0 holds the count; data occupies addresses 1..PARTICLE_NUM-1.
- ADDR_WIDTH, 8: bank address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.
- CELL_ID_WIDTH, 4: width of each cell coordinate.
- CELL_X / CELL_Y / CELL_Z, 1 / 1 / 1: this cell's ID.
- NUM_CH, 2: number of broadcast input channels, 1..4.
- FIFO_DEPTH, 8: staging FIFO entries, power of two, >= 2*NUM_CH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- motion_update_enable  in  1  held high for the whole collection window.
- in_read_address  in  ADDR_WIDTH  read address into the active bank.
- in_rden  in  1  read enable.
- in_data  in  NUM_CH*3*DATA_WIDTH  channel c occupies bits [c*3*DATA_WIDTH +: 3*DATA_WIDTH].
- in_data_dst_cell  in  NUM_CH*3*CELL_ID_WIDTH  per-channel destination {x,y,z}.
- in_data_valid  in  NUM_CH  per-channel valid.
- in_ready  out  1  high when FIFO free entries >= NUM_CH; combinational from FIFO count.
- out_particle_info  out  3*DATA_WIDTH  read data.
- out_particle_num  out  ADDR_WIDTH  particle count of the active bank.
- out_busy  out  1  high in any state other than IDLE.
- out_overflow  out  1  sticky error flag.

## Operation
- Banks: bank 0 is the preloaded cell memory and bank 1 starts empty. Both have 1-cycle registered read latency. active_bank selects which bank serves reads; the other bank receives writes. The active bank never receives writes, and the shadow bank's read enable is held low.
- Match: a channel matches when in_data_valid[c] is high and in_data_dst_cell[c] equals {CELL_X, CELL_Y, CELL_Z}.
- Capture occurs in IDLE while motion_update_enable is high, and in COLLECT.
  - In a capture cycle, all matching channels are pushed into the FIFO in ascending channel order, so channel 0 gets the lower address.
  - If matches occur while in_ready is low, those matches are discarded and out_overflow is set.
- Drain: whenever the FIFO is non-empty in COLLECT or DRAIN, one entry per cycle is written to the shadow bank at address wr_cnt, and wr_cnt increments.
  - wr_cnt resets to 1 at the IDLE->COLLECT transition.
  - If wr_cnt == PARTICLE_NUM, the entry is popped without a write, out_overflow is set, and wr_cnt holds.
- FSM:
  - IDLE -> COLLECT on motion_update_enable. This clears out_overflow and captures in the same cycle.
  - COLLECT -> DRAIN when motion_update_enable is low. Inputs are not captured in DRAIN.
  - DRAIN -> WRITE_NUM when the FIFO is empty.
  - WRITE_NUM: writes wr_cnt-1, zero-extended, to address 0 of the shadow bank; goes to SWAP.
  - SWAP: flips active_bank, loads out_particle_num <= wr_cnt-1, goes to IDLE.
- If motion_update_enable re-asserts during DRAIN, WRITE_NUM or SWAP, it is ignored. It is sampled again in IDLE.
- Reset values: state IDLE, active_bank 0, FIFO empty, wr_cnt 1, out_particle_num 0, out_overflow 0, out_busy 0, out_particle_info 0, in_ready 1.
- Reset mid-update: the FSM returns to IDLE with bank 0 active, and partial shadow writes are abandoned.

## Timing
- Read: in_read_address and in_rden sampled at edge N give out_particle_info after edge N+1.
- Write path: a match at edge N is in the FIFO after N. With an empty FIFO, its bank write happens at edge N+1.
- Sustained input above one match per cycle fills the FIFO; in_ready drops once fewer than NUM_CH entries are free.
- Swap latency: with k entries buffered when enable falls, the last data write occurs k cycles after entering DRAIN. WRITE_NUM follows 1 cycle later, and SWAP 1 cycle after that.
- A read issued in the cycle after SWAP targets the new bank.
- out_particle_num updates at the same edge as active_bank.

## Configuration
- POS_CACHE_OUT_REG_EN defined: adds an output register after the bank mux. Read latency becomes 2 cycles, and out_particle_info resets to 0.
- Undefined: read latency is 1 cycle, and out_particle_info is driven directly from the bank mux.
- Write path and FSM timing are identical in both builds.

## Test plan
- Reset, then read address 0 and address 1 of bank 0 -> preloaded count and first record after 1 cycle (2 with POS_CACHE_OUT_REG_EN). out_particle_num=0, out_busy=0.
- NUM_CH=2, CELL=(1,1,1). Enable high for 3 cycles; both channels match every cycle with records A0..A5 -> shadow addresses 1..6 hold A0,A1,...,A5 in channel order. Address 0 holds 6, out_particle_num=6 after SWAP, and reads switch to bank 1.
- Non-matching destinations on all channels with valid high -> no data writes. Address 0 is written with 0, and the banks swap.
- Sustained 2 matches/cycle with FIFO_DEPTH=8 -> in_ready falls when 7 entries are buffered. Matches injected while in_ready is low set out_overflow, and it clears at the next update start.
- PARTICLE_NUM=4 with 5 matches -> addresses 1..3 written, count=3, out_overflow=1.
- Assert rst during DRAIN -> next cycle: IDLE, bank 0 active, out_busy=0, FIFO empty, original bank 0 contents readable.
